// File: rtl/simplez_loader_pkg.sv
// Shared constants and state encoding for the Simplez serial program loader.
package simplez_loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] ACK_BYTE  = 8'h4B;
  localparam logic [7:0] NAK_BYTE  = 8'h45;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_COUNT = 3'd1,
    ST_WHI   = 3'd2,
    ST_WLO   = 3'd3,
    ST_CSUM  = 3'd4,
    ST_REPLY = 3'd5,
    ST_RUN   = 3'd6
  } state_t;

  // Bits of the HI byte that lie above the word; any of them set marks a malformed word.
  function automatic logic [7:0] hi_mask(input int dw);
    logic [15:0] w;
    w = 16'hFF00 >> (16 - dw);
    return w[7:0];
  endfunction

endpackage

// File: rtl/simplez_loader.sv
// Serial program loader: decodes a framed image from uart_rx bytes, writes it into
// the Simplez RAM from address 0, and releases the CPU once the checksum passes.
//
// state | meaning
// IDLE  | waiting for the SYNC byte, everything else dropped
// COUNT | next byte is the word count N
// WHI   | next byte is the high part of a word
// WLO   | next byte is the low part; the word is written one cycle later
// CSUM  | next byte is the checksum
// REPLY | ACK/NAK latched, waiting for uart_tx to go idle
// RUN   | image loaded, CPU running; loader is deaf until reset
module simplez_loader
  import simplez_loader_pkg::*;
#(
  parameter int         AW      = 3,
  parameter int         DW      = 12,
  parameter logic [7:0] SYNC    = SYNC_BYTE,
  parameter logic [7:0] ACK     = ACK_BYTE,
  parameter logic [7:0] NAK     = NAK_BYTE,
  parameter int         TIMEOUT = 1200000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rcv,
  input  logic [7:0]    rx_data,
  input  logic          tx_ready,
  output logic          tx_start,
  output logic [7:0]    tx_data,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  output logic          cpu_rstn,
  output logic          busy,
  output logic          err
);

  localparam int            TW     = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LOAD = TW'(TIMEOUT - 1);
  localparam logic [7:0]    HMASK  = hi_mask(DW);
  localparam logic [8:0]    N_MAX  = 9'(2 ** AW);

  state_t        state;
  logic [AW-1:0] idx;
  logic [AW-1:0] n_last;
  logic [7:0]    hi_q;
  logic [7:0]    sum;
  logic          fmt_bad;
  logic          reply_ack;
  logic [TW-1:0] tmr;

  // Frame decoder, write strobe, reply handshake and inter-byte timeout in one machine.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      n_last    <= '0;
      hi_q      <= '0;
      sum       <= '0;
      fmt_bad   <= 1'b0;
      reply_ack <= 1'b0;
      tmr       <= '0;
      tx_start  <= 1'b0;
      tx_data   <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= '0;
      cpu_rstn  <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_we   <= 1'b0;
      tx_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rcv && rx_data == SYNC) begin
            state   <= ST_COUNT;
            err     <= 1'b0;
            idx     <= '0;
            sum     <= '0;
            fmt_bad <= 1'b0;
            tmr     <= T_LOAD;
            busy    <= 1'b1;
          end
        end
        ST_COUNT, ST_WHI, ST_WLO, ST_CSUM: begin
          // The timeout is checked first so it wins over a byte arriving in the same cycle.
          if (tmr == '0) begin
            state     <= ST_REPLY;
            tx_data   <= NAK;
            reply_ack <= 1'b0;
            err       <= 1'b1;
          end else if (rcv) begin
            tmr <= T_LOAD;
            case (state)
              ST_COUNT: begin
                if (rx_data == 8'd0 || {1'b0, rx_data} > N_MAX) begin
                  state     <= ST_REPLY;
                  tx_data   <= NAK;
                  reply_ack <= 1'b0;
                  err       <= 1'b1;
                end else begin
                  n_last <= AW'(rx_data - 8'd1);
                  state  <= ST_WHI;
                end
              end
              ST_WHI: begin
                hi_q <= rx_data;
                sum  <= sum + rx_data;
                if ((rx_data & HMASK) != 8'd0) fmt_bad <= 1'b1;
                state <= ST_WLO;
              end
              ST_WLO: begin
                sum      <= sum + rx_data;
                mem_we   <= 1'b1;
                mem_addr <= idx;
                mem_din  <= {hi_q[DW-9:0], rx_data};
                idx      <= idx + AW'(1);
                state    <= (idx == n_last) ? ST_CSUM : ST_WHI;
              end
              default: begin
                state <= ST_REPLY;
                if (rx_data == sum && !fmt_bad) begin
                  tx_data   <= ACK;
                  reply_ack <= 1'b1;
                end else begin
                  tx_data   <= NAK;
                  reply_ack <= 1'b0;
                  err       <= 1'b1;
                end
              end
            endcase
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        ST_REPLY: begin
          if (tx_ready) begin
            tx_start <= 1'b1;
            busy     <= 1'b0;
            if (reply_ack) begin
              state    <= ST_RUN;
              cpu_rstn <= 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_RUN: begin
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simplez_loader.sv
// Directed bench for simplez_loader: frames are fed byte by byte, RAM writes and
// replies are logged by a monitor and compared against hand-computed values.
module tb_simplez_loader;

  localparam int AW = 3;
  localparam int DW = 12;
  localparam int TO = 40;

  logic          clk = 1'b0;
  logic          rst;
  logic          rcv;
  logic [7:0]    rx_data;
  logic          tx_ready;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic          cpu_rstn;
  logic          busy;
  logic          err;

  simplez_loader #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .rcv(rcv), .rx_data(rx_data), .tx_ready(tx_ready),
    .tx_start(tx_start), .tx_data(tx_data), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .cpu_rstn(cpu_rstn), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int rcv_cyc = 0;

  logic [15:0] we_log[$];
  int          we_lat[$];
  logic [7:0]  tx_log[$];
  int          tx_lat[$];

  // Cycle counter for latency measurements.
  always @(posedge clk) cyc <= cyc + 1;

  // Log every write strobe and reply pulse with its distance from the last received byte.
  always @(negedge clk) begin
    if (mem_we) begin
      we_log.push_back({1'b0, mem_addr, mem_din});
      we_lat.push_back(cyc - rcv_cyc);
    end
    if (tx_start) begin
      tx_log.push_back(tx_data);
      tx_lat.push_back(cyc - rcv_cyc);
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    we_log.delete();
    we_lat.delete();
    tx_log.delete();
    tx_lat.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rcv = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    clear_logs();
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rcv = 1'b1;
    rx_data = b;
    rcv_cyc = cyc;
    @(negedge clk);
    rcv = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] f[$]);
    foreach (f[i]) send_byte(f[i]);
  endtask

  task automatic wait_tx(input string tag, input int n_exp, input int max_cyc);
    int k;
    k = 0;
    while (tx_log.size() < n_exp && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    check_val(tag, tx_log.size(), n_exp);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_lat();
    foreach (we_lat[i]) check_val("we_latency", we_lat[i], 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] f[$];
    logic [7:0] s;
    rst = 1'b1;
    rcv = 1'b0;
    rx_data = 8'h00;
    tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_mem_we", mem_we, 0);
    check_val("rst_tx_start", tx_start, 0);
    check_val("rst_cpu_rstn", cpu_rstn, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_err", err, 0);
    check_val("rst_addr", mem_addr, 0);
    check_val("rst_din", mem_din, 0);
    check_val("rst_tx_data", tx_data, 0);
    do_reset();

    // Good two-word frame: 01+23+0A+BC = EA.
    send_byte(8'hA5);
    check_val("t1_busy_in_frame", busy, 1);
    send_frame('{8'h02, 8'h01, 8'h23, 8'h0A, 8'hBC, 8'hEA});
    wait_tx("t1_tx_wait", 1, 10);
    check_val("t1_we_count", we_log.size(), 2);
    if (we_log.size() == 2) begin
      check_val("t1_word0", we_log[0], 16'h0123);
      check_val("t1_word1", we_log[1], 16'h1ABC);
    end
    check_lat();
    if (tx_log.size() == 1) check_val("t1_ack", tx_log[0], 8'h4B);
    check_val("t1_cpu_rstn", cpu_rstn, 1);
    check_val("t1_busy", busy, 0);
    check_val("t1_err", err, 0);
    // In RUN the loader ignores every byte.
    send_frame('{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00});
    repeat (4) @(negedge clk);
    check_val("run_we_count", we_log.size(), 2);
    check_val("run_tx_count", tx_log.size(), 1);
    check_val("run_cpu_rstn", cpu_rstn, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("run_rst_cpu_rstn", cpu_rstn, 0);
    check_val("run_rst_busy", busy, 0);
    check_val("run_rst_we", mem_we, 0);
    do_reset();

    // Same frame with a wrong checksum, then a good frame clears err.
    send_frame('{8'hA5, 8'h02, 8'h01, 8'h23, 8'h0A, 8'hBC, 8'hEB});
    wait_tx("t2_tx_wait", 1, 10);
    check_val("t2_we_count", we_log.size(), 2);
    if (we_log.size() == 2) check_val("t2_word1", we_log[1], 16'h1ABC);
    if (tx_log.size() == 1) check_val("t2_nak", tx_log[0], 8'h45);
    check_val("t2_err", err, 1);
    check_val("t2_cpu_rstn", cpu_rstn, 0);
    check_val("t2_busy", busy, 0);
    send_byte(8'hA5);
    check_val("t2_err_cleared_on_sync", err, 0);
    send_frame('{8'h02, 8'h01, 8'h23, 8'h0A, 8'hBC, 8'hEA});
    wait_tx("t2b_tx_wait", 2, 10);
    if (tx_log.size() == 2) check_val("t2b_ack", tx_log[1], 8'h4B);
    check_val("t2b_err", err, 0);
    check_val("t2b_cpu_rstn", cpu_rstn, 1);
    do_reset();

    // Word count out of range: immediate NAK, nothing written.
    send_frame('{8'hA5, 8'h00});
    wait_tx("t3_n0_tx_wait", 1, 10);
    send_frame('{8'hA5, 8'h09});
    wait_tx("t3_n9_tx_wait", 2, 10);
    check_val("t3_we_count", we_log.size(), 0);
    if (tx_log.size() == 2) begin
      check_val("t3_n0_nak", tx_log[0], 8'h45);
      check_val("t3_n9_nak", tx_log[1], 8'h45);
    end
    check_val("t3_busy", busy, 0);
    check_val("t3_cpu_rstn", cpu_rstn, 0);

    // Largest image: 8 words, word i = {i, i*0x11}.
    f = '{8'hA5, 8'h08};
    s = 8'h00;
    for (int i = 0; i < 8; i++) begin
      f.push_back(8'(i));
      f.push_back(8'(i * 17));
      s = s + 8'(i) + 8'(i * 17);
    end
    f.push_back(s);
    clear_logs();
    send_frame(f);
    wait_tx("t3_max_tx_wait", 1, 10);
    check_val("t3_max_we_count", we_log.size(), 8);
    if (we_log.size() == 8) begin
      check_val("t3_max_word0", we_log[0], 16'h0000);
      check_val("t3_max_word7", we_log[7], 16'h7777);
    end
    if (tx_log.size() == 1) check_val("t3_max_ack", tx_log[0], 8'h4B);
    check_lat();
    do_reset();

    // HI byte with upper nibble set: sum F1+23=14 matches but the frame is rejected.
    send_frame('{8'hA5, 8'h01, 8'hF1, 8'h23, 8'h14});
    wait_tx("t4_tx_wait", 1, 10);
    if (tx_log.size() == 1) check_val("t4_nak", tx_log[0], 8'h45);
    check_val("t4_err", err, 1);
    check_val("t4_cpu_rstn", cpu_rstn, 0);
    do_reset();

    // Silence after the first word: timeout decided TO cycles after the last byte,
    // reply pulse one cycle later.
    send_frame('{8'hA5, 8'h02, 8'h01, 8'h23});
    wait_tx("t5_tx_wait", 1, TO + 20);
    check_val("t5_we_count", we_log.size(), 1);
    if (tx_log.size() == 1) begin
      check_val("t5_nak", tx_log[0], 8'h45);
      check_val("t5_timeout_latency", tx_lat[0], TO + 2);
    end
    check_val("t5_err", err, 1);
    check_val("t5_busy", busy, 0);
    send_frame('{8'h00, 8'hFF});
    check_val("t5_stray_busy", busy, 0);
    send_frame('{8'hA5, 8'h01, 8'h01, 8'h23, 8'h24});
    wait_tx("t5b_tx_wait", 2, 10);
    if (tx_log.size() == 2) check_val("t5b_ack", tx_log[1], 8'h4B);
    check_val("t5b_cpu_rstn", cpu_rstn, 1);
    do_reset();

    // Reset arriving together with the LO byte: no write, straight back to IDLE.
    send_frame('{8'hA5, 8'h02, 8'h01});
    @(negedge clk);
    rst = 1'b1;
    rcv = 1'b1;
    rx_data = 8'h23;
    @(negedge clk);
    rst = 1'b0;
    rcv = 1'b0;
    check_val("t6_rst_we", mem_we, 0);
    check_val("t6_rst_busy", busy, 0);
    check_val("t6_rst_cpu_rstn", cpu_rstn, 0);
    check_val("t6_rst_tx_start", tx_start, 0);
    repeat (3) @(negedge clk);
    check_val("t6_rst_we_count", we_log.size(), 0);

    // Reply held off while uart_tx is busy.
    tx_ready = 1'b0;
    send_frame('{8'hA5, 8'h00});
    repeat (10) @(negedge clk);
    check_val("t6_hold_tx_count", tx_log.size(), 0);
    check_val("t6_hold_busy", busy, 1);
    tx_ready = 1'b1;
    wait_tx("t6_tx_wait", 1, 10);
    if (tx_log.size() == 1) check_val("t6_nak", tx_log[0], 8'h45);
    check_val("t6_busy_after", busy, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
